// File: rtl/instr_queue_pkg.sv
// rtl/instr_queue_pkg.sv - shared widths and entry layout for the instruction queue
package instr_queue_pkg;

    localparam int DATA_W           = 32;
    localparam int IQ_DEPTH_LOG_DEF = 4;
    localparam int IQ_ENTRY_W       = 2 * DATA_W + 1;

    // One queued instruction; pred_taken is the MSB of the 65-bit entry.
    typedef struct packed {
        logic              pred_taken;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } iq_entry_t;

endpackage

// File: rtl/instr_queue.sv
// rtl/instr_queue.sv - in-order FWFT instruction queue between fetch and issue
module instr_queue
    import instr_queue_pkg::*;
#(
    parameter int IQ_DEPTH_LOG = IQ_DEPTH_LOG_DEF,
    parameter int FULL_SLACK   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_instr,
    input  logic [DATA_W-1:0] in_pc,
    input  logic              in_pred_taken,
    output logic              is_full,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_instr,
    output logic [DATA_W-1:0] out_pc,
    output logic              out_pred_taken,
    output logic              overflow
);

    localparam int DEPTH = 1 << IQ_DEPTH_LOG;
    localparam logic [IQ_DEPTH_LOG:0] DEPTH_C  = (IQ_DEPTH_LOG+1)'(DEPTH);
    localparam logic [IQ_DEPTH_LOG:0] FULL_THR = (IQ_DEPTH_LOG+1)'(DEPTH - FULL_SLACK);

    logic [IQ_ENTRY_W-1:0]   r_mem [DEPTH];
    logic [IQ_DEPTH_LOG-1:0] r_head;
    logic [IQ_DEPTH_LOG-1:0] r_tail;
    logic [IQ_DEPTH_LOG:0]   r_count;
    logic                    r_overflow;

    logic                    w_active;
    logic                    w_pop;
    logic                    w_push;
    logic                    w_drop;
    logic [IQ_DEPTH_LOG:0]   w_count_next;
    iq_entry_t               w_in_entry;
    iq_entry_t               w_head_entry;

    // A frozen (rdy=0) or flushing cycle neither pushes nor pops.
    assign w_active = rdy & ~flush;
    assign w_pop    = w_active & out_valid & out_ready;
    assign w_push   = w_active & in_valid & ((r_count < DEPTH_C) | w_pop);
    assign w_drop   = w_active & in_valid & ~w_push;

    assign w_in_entry   = '{pred_taken: in_pred_taken, pc: in_pc, instr: in_instr};
    assign w_head_entry = iq_entry_t'(r_mem[r_head]);

    assign out_valid      = (r_count != '0);
    assign is_full        = (r_count >= FULL_THR);
    assign out_instr      = w_head_entry.instr;
    assign out_pc         = w_head_entry.pc;
    assign out_pred_taken = w_head_entry.pred_taken;
    assign overflow       = r_overflow;

    // Occupancy update: a push and pop in the same cycle cancel out.
    always_comb begin
        w_count_next = r_count;
        unique case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    // Pointer, occupancy and sticky overflow state; flush empties the queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (rdy) begin
            if (flush) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) r_tail <= r_tail + 1'b1;
                if (w_pop)  r_head <= r_head + 1'b1;
                r_count <= w_count_next;
                if (w_drop) r_overflow <= 1'b1;
            end
        end
    end

    // Entry storage is not reset; validity comes from the occupancy count.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_tail] <= w_in_entry;
    end

endmodule

// File: tb/tb_instr_queue.sv
// tb/tb_instr_queue.sv - self-checking bench for instr_queue
module tb_instr_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        in_pred_taken;
    logic        out_ready;
    logic        is_full;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_pred_taken;
    logic        overflow;

    int n_tests = 0;
    int n_fail  = 0;

    instr_queue dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_instr       (in_instr),
        .in_pc          (in_pc),
        .in_pred_taken  (in_pred_taken),
        .is_full        (is_full),
        .out_ready      (out_ready),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_pred_taken (out_pred_taken),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an unbounded queue capped at 16 by the push rule.
    logic [64:0] m_q [$];
    logic        m_ovf;
    int          m_pushes;
    bit          m_pop;
    bit          m_push;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_ovf = 1'b0;
        end else if (rdy && flush) begin
            m_q.delete();
        end else if (rdy) begin
            m_pop  = out_ready && (m_q.size() != 0);
            m_push = in_valid && ((m_q.size() < 16) || m_pop);
            if (in_valid && !m_push) m_ovf = 1'b1;
            if (m_pop) void'(m_q.pop_front());
            if (m_push) begin
                m_q.push_back({in_pred_taken, in_pc, in_instr});
                m_pushes++;
            end
        end
    end

    always @(negedge clk) begin
        check("out_valid", 65'(out_valid), 65'(m_q.size() != 0));
        check("is_full", 65'(is_full), 65'(m_q.size() >= 15));
        check("overflow", 65'(overflow), 65'(m_ovf));
        if (m_q.size() != 0)
            check("head_entry", {out_pred_taken, out_pc, out_instr}, m_q[0]);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [31:0] pc, input logic orr);
        in_valid      = iv;
        in_pc         = pc;
        in_instr      = pc ^ 32'h1234_5678;
        in_pred_taken = pc[2];
        out_ready     = orr;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        int start;
        m_pushes = 0;
        rst = 1'b1; rdy = 1'b1; flush = 1'b0;
        in_valid = 1'b0; in_instr = '0; in_pc = '0; in_pred_taken = 1'b0; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        check("rst_out_valid", 65'(out_valid), 65'd0);
        check("rst_is_full", 65'(is_full), 65'd0);
        check("rst_overflow", 65'(overflow), 65'd0);

        // Fill to 16, then a dropped 17th push, then in-order drain.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 32'(i * 4), 1'b0);
            check("fill_is_full", 65'(is_full), 65'(i + 1 >= 15));
        end
        drive(1'b1, 32'h40, 1'b0);
        check("drop_overflow", 65'(overflow), 65'd1);
        check("drop_out_valid", 65'(out_valid), 65'd1);
        for (int i = 0; i < 16; i++) begin
            check("drain_pc", 65'(out_pc), 65'(i * 4));
            check("drain_instr", 65'(out_instr), 65'((i * 4) ^ 32'h1234_5678));
            drive(1'b0, 32'h0, 1'b1);
        end
        check("drained_valid", 65'(out_valid), 65'd0);
        check("overflow_sticky", 65'(overflow), 65'd1);

        // Mid-run asynchronous reset with five entries queued.
        for (int i = 0; i < 5; i++) drive(1'b1, 32'h80 + 32'(i * 4), 1'b0);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst_out_valid", 65'(out_valid), 65'd0);
        check("arst_is_full", 65'(is_full), 65'd0);
        check("arst_overflow", 65'(overflow), 65'd0);
        tick();
        rst = 1'b0;
        tick(); tick();
        check("post_rst_valid", 65'(out_valid), 65'd0);

        // Simultaneous push and pop at full occupancy.
        for (int i = 0; i < 16; i++) drive(1'b1, 32'h100 + 32'(i * 4), 1'b0);
        drive(1'b1, 32'h200, 1'b1);
        check("simul_head_pc", 65'(out_pc), 65'h104);
        check("simul_overflow", 65'(overflow), 65'd0);
        check("simul_is_full", 65'(is_full), 65'd1);
        for (int i = 0; i < 16; i++) drive(1'b0, 32'h0, 1'b1);
        check("simul_drained", 65'(out_valid), 65'd0);

        // Streaming with random back-pressure across pointer wrap.
        start = m_pushes;
        guard = 0;
        while ((m_pushes < start + 40) && (guard < 1000)) begin
            drive(!is_full && ($urandom_range(0, 3) != 0),
                  32'h1000 + 32'((m_pushes - start) * 4),
                  1'($urandom_range(0, 1)));
            guard++;
        end
        check("stream_bound", 65'(guard < 1000), 65'd1);
        guard = 0;
        while (out_valid && (guard < 100)) begin
            drive(1'b0, 32'h0, 1'b1);
            guard++;
        end
        check("stream_drained", 65'(out_valid), 65'd0);
        check("stream_overflow", 65'(overflow), 65'd0);

        // Flush with a same-cycle push and pop request.
        for (int i = 0; i < 7; i++) drive(1'b1, 32'h300 + 32'(i * 4), 1'b0);
        flush = 1'b1;
        drive(1'b1, 32'h3FC, 1'b1);
        flush = 1'b0;
        check("flush_out_valid", 65'(out_valid), 65'd0);
        check("flush_is_full", 65'(is_full), 65'd0);
        drive(1'b1, 32'h400, 1'b0);
        check("post_flush_pc", 65'(out_pc), 65'h400);
        check("post_flush_valid", 65'(out_valid), 65'd1);
        drive(1'b0, 32'h0, 1'b1);
        check("post_flush_empty", 65'(out_valid), 65'd0);

        // Freeze with rdy low while requests toggle.
        for (int i = 0; i < 3; i++) drive(1'b1, 32'h500 + 32'(i * 4), 1'b0);
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            flush = (k == 1);
            drive(1'(k % 2 == 0), 32'h600, 1'(k != 1));
            check("freeze_pc", 65'(out_pc), 65'h500);
            check("freeze_valid", 65'(out_valid), 65'd1);
        end
        rdy = 1'b1;
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("unfreeze_pc", 65'(out_pc), 65'h500 + 65'(i * 4));
            drive(1'b0, 32'h0, 1'b1);
        end
        check("unfreeze_empty", 65'(out_valid), 65'd0);

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
